text_menu_nav: RTL and testbench
================================

// Module: text_menu_nav
// PURPOSE
//  Keyboard-side driver of the top text-editor menu: turns PS/2 scan-code bytes into the
//  item_selector consumed by the menu graph renderer, and into command pulses.
//  Sits between the PS/2 receiver (byte + strobe) and the menu graph/editor core.
//  Also holds the caps/color/size editor settings selected through the menu.
// PARAMETERS
//  MENU_KEY   8'h09        non-extended make code that opens the menu (F10)
//  TIMEOUT    28'd250_000_000  idle cycles before the open menu auto-closes; 0 = never
//  SIZE_MAX   2'd3         highest text-size index; size wraps SIZE_MAX -> 0
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-low reset
//  key_code      in   8  scan-code byte from PS/2 receiver
//  key_valid     in   1  1-cycle strobe, key_code valid
//  item_selector out  3  0 = menu closed, 1..6 = highlighted item (open,save,exit,caps,color,size)
//  menu_active   out  1  1 while menu open (item_selector != 0)
//  cmd_valid     out  1  1-cycle pulse: item confirmed with Enter
//  cmd_item      out  3  item confirmed; valid with cmd_valid, holds last value otherwise
//  caps_on       out  1  caps-lock setting
//  text_color    out  3  text rgb, range 3'b001..3'b111
//  text_size     out  2  size index 0..SIZE_MAX
// BEHAVIOUR
//  Reset (reset==0 at clk edge): item_selector=0, menu_active=0, cmd_valid=0, cmd_item=0,
//   caps_on=0, text_color=3'b111, text_size=0, prefix FSM=P_IDLE, timeout counter=0.
//  Prefix FSM, advances only on key_valid:
//   P_IDLE: E0->P_E0; F0->P_F0; other -> decode as normal make, stay P_IDLE.
//   P_E0:   F0->P_E0F0; E0->P_E0; other -> decode as extended make, ->P_IDLE.
//   P_F0, P_E0F0: any byte -> P_IDLE, byte discarded (break codes never act).
//  Decoded make events: OPEN = normal MENU_KEY; LEFT = ext 6B; RIGHT = ext 74;
//   ENTER = normal 5A; ESC = normal 76. All other makes ignored.
//  Menu closed: OPEN -> item_selector=1. All other events ignored.
//  Menu open:
//   LEFT: sel-1, 1 wraps to 6. RIGHT: sel+1, 6 wraps to 1. OPEN: no effect.
//   ESC: item_selector=0.
//   ENTER: cmd_valid=1, cmd_item=sel. Items 1-3: menu closes (item_selector=0) same edge.
//    Item 4: caps_on toggles. Item 5: text_color+1, 7 wraps to 1 (0 never output).
//    Item 6: text_size+1, SIZE_MAX wraps to 0. Items 4-6 keep menu open, sel unchanged.
//  Latency: all outputs update on the clk edge after the final byte's key_valid cycle
//   (1 cycle); cmd_valid high exactly one cycle; at most one event per key_valid.
//  Timeout: counter counts while menu open and no key_valid; any key_valid byte
//   (incl. prefixes/breaks) clears it. Reaching TIMEOUT-1 closes menu, clears counter.
//   Counter held at 0 while closed. key_valid in the expiry cycle wins: event processed,
//   counter cleared, no close.
//  Reset mid-sequence (e.g., after E0): FSM returns P_IDLE, partial code dropped.
//  item_selector never holds 7; menu_active == (item_selector != 0) at all times.
// TESTING
//  1 reset low 2 cycles -> sel=0, caps_on=0, text_color=7, text_size=0, cmd_valid=0.
//  2 09 then E0 74 x6 -> sel 1,2,3,4,5,6,1; E0 6B -> sel=6; break E0 F0 74 -> sel unchanged.
//  3 sel=5, 5A x2 -> two cmd_valid pulses cmd_item=5, text_color 7->1->2, menu stays open;
//    sel=2, 5A -> cmd_item=2, item_selector=0 next cycle.
//  4 F0 5A while sel=4 -> no cmd_valid, caps_on unchanged; 76 -> sel=0; 74 without E0 ignored.
//  5 TIMEOUT=16: open, idle 16 cycles -> sel=0 at cycle 16; key byte on cycle 15 -> stays open.
//  6 E0 then reset low 1 cycle then 74 -> treated as normal 74 (ignored), sel unchanged.

Source files
------------

// File: rtl/text_menu_nav.sv
// text_menu_nav
//   Keyboard-side driver of the editor's top menu. It takes scan-code bytes
//   from the PS/2 receiver and produces three things: the highlighted menu
//   item for the menu graph renderer, one-cycle command pulses when an item
//   is confirmed, and the caps/color/size editor settings changed from the
//   menu.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-low reset
//   key_code      scan-code byte from the PS/2 receiver
//   key_valid     one-cycle strobe marking key_code as valid
//   item_selector 0 = menu closed, 1..6 = highlighted item
//                 (open, save, exit, caps, color, size)
//   menu_active   high while the menu is open
//   cmd_valid     one-cycle pulse when an item is confirmed with Enter
//   cmd_item      confirmed item; holds its last value between pulses
//   caps_on       caps-lock setting
//   text_color    text rgb, always in 3'b001..3'b111
//   text_size     text size index, 0..SIZE_MAX
module text_menu_nav #(
    parameter logic [7:0]  MENU_KEY = 8'h09,
    parameter logic [27:0] TIMEOUT  = 28'd250_000_000,
    parameter logic [1:0]  SIZE_MAX = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic [2:0] item_selector,
    output logic       menu_active,
    output logic       cmd_valid,
    output logic [2:0] cmd_item,
    output logic       caps_on,
    output logic [2:0] text_color,
    output logic [1:0] text_size
);

    // Prefix tracking for the PS/2 set-2 byte stream: E0 marks an extended
    // code, F0 marks a break (key release).
    typedef enum logic [1:0] {P_IDLE, P_E0, P_F0, P_E0F0} prefix_t;

    typedef enum logic [2:0] {EV_NONE, EV_OPEN, EV_LEFT, EV_RIGHT, EV_ENTER, EV_ESC} event_t;

    prefix_t     state, state_next;
    event_t      key_event;
    logic [2:0]  sel_next;
    logic        cmd_valid_next;
    logic [2:0]  cmd_item_next;
    logic        caps_next;
    logic [2:0]  color_next;
    logic [1:0]  size_next;
    logic [27:0] idle_count, count_next;

    assign menu_active = (item_selector != 3'd0);

    // Register stage: every output is registered, so each byte acts on the
    // edge that closes its key_valid cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= P_IDLE;
            item_selector <= 3'd0;
            cmd_valid     <= 1'b0;
            cmd_item      <= 3'd0;
            caps_on       <= 1'b0;
            text_color    <= 3'b111;
            text_size     <= 2'd0;
            idle_count    <= 28'd0;
        end else begin
            state         <= state_next;
            item_selector <= sel_next;
            cmd_valid     <= cmd_valid_next;
            cmd_item      <= cmd_item_next;
            caps_on       <= caps_next;
            text_color    <= color_next;
            text_size     <= size_next;
            idle_count    <= count_next;
        end
    end

    // Prefix decoding: turns a complete make code into at most one event.
    // Break sequences only return the FSM to idle and never produce events.
    always_comb begin
        state_next = state;
        key_event  = EV_NONE;
        if (key_valid) begin
            case (state)
                P_IDLE: begin
                    if (key_code == 8'hE0) begin
                        state_next = P_E0;
                    end else if (key_code == 8'hF0) begin
                        state_next = P_F0;
                    end else if (key_code == MENU_KEY) begin
                        key_event = EV_OPEN;
                    end else if (key_code == 8'h5A) begin
                        key_event = EV_ENTER;
                    end else if (key_code == 8'h76) begin
                        key_event = EV_ESC;
                    end
                end
                P_E0: begin
                    if (key_code == 8'hF0) begin
                        state_next = P_E0F0;
                    end else if (key_code == 8'hE0) begin
                        state_next = P_E0;
                    end else begin
                        state_next = P_IDLE;
                        if (key_code == 8'h6B) begin
                            key_event = EV_LEFT;
                        end else if (key_code == 8'h74) begin
                            key_event = EV_RIGHT;
                        end
                    end
                end
                default: state_next = P_IDLE;
            endcase
        end
    end

    // Menu behaviour and idle timeout. The timeout can only fire in a cycle
    // without key_valid, so a byte arriving in the expiry cycle keeps the
    // menu open and restarts the count.
    always_comb begin
        sel_next       = item_selector;
        cmd_valid_next = 1'b0;
        cmd_item_next  = cmd_item;
        caps_next      = caps_on;
        color_next     = text_color;
        size_next      = text_size;
        count_next     = idle_count;

        if (item_selector == 3'd0) begin
            if (key_event == EV_OPEN) begin
                sel_next = 3'd1;
            end
        end else begin
            case (key_event)
                EV_LEFT:  sel_next = (item_selector == 3'd1) ? 3'd6 : item_selector - 3'd1;
                EV_RIGHT: sel_next = (item_selector >= 3'd6) ? 3'd1 : item_selector + 3'd1;
                EV_ESC:   sel_next = 3'd0;
                EV_ENTER: begin
                    cmd_valid_next = 1'b1;
                    cmd_item_next  = item_selector;
                    case (item_selector)
                        3'd4:    caps_next  = ~caps_on;
                        3'd5:    color_next = (text_color == 3'd7) ? 3'd1 : text_color + 3'd1;
                        3'd6:    size_next  = (text_size >= SIZE_MAX) ? 2'd0 : text_size + 2'd1;
                        default: sel_next   = 3'd0;
                    endcase
                end
                default: ;
            endcase
        end

        if (item_selector == 3'd0 || key_valid || TIMEOUT == 28'd0) begin
            count_next = 28'd0;
        end else if (idle_count == TIMEOUT - 28'd1) begin
            count_next = 28'd0;
            sel_next   = 3'd0;
        end else begin
            count_next = idle_count + 28'd1;
        end
    end

endmodule

// File: tb/tb_text_menu_nav.sv
// tb_text_menu_nav
//   Self-checking bench for text_menu_nav with a short idle timeout (16).
//   A table of scan-code bytes with the expected outputs after each byte
//   drives the main navigation/command paths; hand-written sequences cover
//   reset, idle timeout, and reset in the middle of an extended code.
module tb_text_menu_nav;

    localparam logic [27:0] TB_TIMEOUT = 28'd16;

    logic       clk;
    logic       reset;
    logic [7:0] key_code;
    logic       key_valid;
    logic [2:0] item_selector;
    logic       menu_active;
    logic       cmd_valid;
    logic [2:0] cmd_item;
    logic       caps_on;
    logic [2:0] text_color;
    logic [1:0] text_size;

    typedef struct {
        logic [7:0] code;
        logic [2:0] sel;
        logic       caps;
        logic [2:0] color;
        logic [1:0] size;
        logic       cv;
        logic [2:0] ci;
    } vec_t;

    vec_t vectors[$];
    vec_t scoreboard[$];

    int n_checks = 0;
    int n_fail   = 0;

    text_menu_nav #(
        .MENU_KEY(8'h09),
        .TIMEOUT (TB_TIMEOUT),
        .SIZE_MAX(2'd3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .item_selector(item_selector),
        .menu_active  (menu_active),
        .cmd_valid    (cmd_valid),
        .cmd_item     (cmd_item),
        .caps_on      (caps_on),
        .text_color   (text_color),
        .text_size    (text_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on the whole run in case the bench loses sync with the DUT.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run time exceeded, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_state(input string tag, input vec_t e);
        check_output({tag, " sel"},    {5'd0, item_selector}, {5'd0, e.sel});
        check_output({tag, " active"}, {7'd0, menu_active},   {7'd0, (e.sel != 3'd0)});
        check_output({tag, " cmdv"},   {7'd0, cmd_valid},     {7'd0, e.cv});
        check_output({tag, " cmdi"},   {5'd0, cmd_item},      {5'd0, e.ci});
        check_output({tag, " caps"},   {7'd0, caps_on},       {7'd0, e.caps});
        check_output({tag, " color"},  {5'd0, text_color},    {5'd0, e.color});
        check_output({tag, " size"},   {6'd0, text_size},     {6'd0, e.size});
    endtask

    function automatic void add_vec(input logic [7:0] code, input logic [2:0] sel, input logic caps,
                                    input logic [2:0] color, input logic [1:0] size,
                                    input logic cv, input logic [2:0] ci);
        vec_t v;
        v.code = code; v.sel = sel; v.caps = caps; v.color = color;
        v.size = size; v.cv = cv; v.ci = ci;
        vectors.push_back(v);
    endfunction

    // Drives one byte for one cycle; the expected state is queued when the
    // byte goes out and compared once the DUT has taken the edge.
    task automatic apply_stimulus(input string tag, input vec_t v);
        vec_t e;
        scoreboard.push_back(v);
        key_code  = v.code;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        e = scoreboard.pop_front();
        check_state(tag, e);
    endtask

    task automatic send_byte(input logic [7:0] code);
        key_code  = code;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b0;
        key_code  = 8'h00;
        key_valid = 1'b0;

        // Table: byte, then sel, caps, color, size, cmd_valid, cmd_item after it.
        add_vec(8'h09, 3'd1, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            add_vec(8'hE0, (i == 0) ? 3'd1 : 3'(i + 1), 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
            add_vec(8'h74, (i == 5) ? 3'd1 : 3'(i + 2), 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        end
        add_vec(8'hE0, 3'd1, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        add_vec(8'h6B, 3'd6, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        add_vec(8'hE0, 3'd6, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        add_vec(8'hF0, 3'd6, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        add_vec(8'h74, 3'd6, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        add_vec(8'hE0, 3'd6, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        add_vec(8'h6B, 3'd5, 1'b0, 3'd7, 2'd0, 1'b0, 3'd0);
        add_vec(8'h5A, 3'd5, 1'b0, 3'd1, 2'd0, 1'b1, 3'd5);
        add_vec(8'h5A, 3'd5, 1'b0, 3'd2, 2'd0, 1'b1, 3'd5);
        add_vec(8'hE0, 3'd5, 1'b0, 3'd2, 2'd0, 1'b0, 3'd5);
        add_vec(8'h6B, 3'd4, 1'b0, 3'd2, 2'd0, 1'b0, 3'd5);
        add_vec(8'hE0, 3'd4, 1'b0, 3'd2, 2'd0, 1'b0, 3'd5);
        add_vec(8'h6B, 3'd3, 1'b0, 3'd2, 2'd0, 1'b0, 3'd5);
        add_vec(8'hE0, 3'd3, 1'b0, 3'd2, 2'd0, 1'b0, 3'd5);
        add_vec(8'h6B, 3'd2, 1'b0, 3'd2, 2'd0, 1'b0, 3'd5);
        add_vec(8'h5A, 3'd0, 1'b0, 3'd2, 2'd0, 1'b1, 3'd2);
        add_vec(8'h09, 3'd1, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'hE0, 3'd1, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'h74, 3'd2, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'hE0, 3'd2, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'h74, 3'd3, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'hE0, 3'd3, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'h74, 3'd4, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'hF0, 3'd4, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'h5A, 3'd4, 1'b0, 3'd2, 2'd0, 1'b0, 3'd2);
        add_vec(8'h5A, 3'd4, 1'b1, 3'd2, 2'd0, 1'b1, 3'd4);
        add_vec(8'h74, 3'd4, 1'b1, 3'd2, 2'd0, 1'b0, 3'd4);
        add_vec(8'h09, 3'd4, 1'b1, 3'd2, 2'd0, 1'b0, 3'd4);
        add_vec(8'h76, 3'd0, 1'b1, 3'd2, 2'd0, 1'b0, 3'd4);
        add_vec(8'h5A, 3'd0, 1'b1, 3'd2, 2'd0, 1'b0, 3'd4);
        add_vec(8'h09, 3'd1, 1'b1, 3'd2, 2'd0, 1'b0, 3'd4);
        add_vec(8'hE0, 3'd1, 1'b1, 3'd2, 2'd0, 1'b0, 3'd4);
        add_vec(8'h6B, 3'd6, 1'b1, 3'd2, 2'd0, 1'b0, 3'd4);
        add_vec(8'h5A, 3'd6, 1'b1, 3'd2, 2'd1, 1'b1, 3'd6);
        add_vec(8'h5A, 3'd6, 1'b1, 3'd2, 2'd2, 1'b1, 3'd6);
        add_vec(8'h5A, 3'd6, 1'b1, 3'd2, 2'd3, 1'b1, 3'd6);
        add_vec(8'h5A, 3'd6, 1'b1, 3'd2, 2'd0, 1'b1, 3'd6);
        add_vec(8'h76, 3'd0, 1'b1, 3'd2, 2'd0, 1'b0, 3'd6);

        // Reset held low for two cycles.
        idle_cycles(2);
        reset = 1'b1;
        begin
            vec_t r;
            r.code = 8'h00; r.sel = 3'd0; r.caps = 1'b0; r.color = 3'd7;
            r.size = 2'd0; r.cv = 1'b0; r.ci = 3'd0;
            check_state("reset", r);
        end

        $display("[TB] table of %0d vectors", vectors.size());
        for (int i = 0; i < vectors.size(); i++) begin
            apply_stimulus($sformatf("vec%0d", i), vectors[i]);
        end

        // Idle timeout: open, then the 16th idle edge closes the menu.
        send_byte(8'h09);
        check_output("to_open", {5'd0, item_selector}, 8'd1);
        idle_cycles(15);
        check_output("to_15idle", {5'd0, item_selector}, 8'd1);
        idle_cycles(1);
        check_output("to_16idle", {5'd0, item_selector}, 8'd0);
        check_output("to_active", {7'd0, menu_active}, 8'd0);

        // A byte in the expiry cycle wins and restarts the count.
        send_byte(8'h09);
        idle_cycles(15);
        send_byte(8'h00);
        check_output("to_keywins", {5'd0, item_selector}, 8'd1);
        idle_cycles(15);
        check_output("to_restart15", {5'd0, item_selector}, 8'd1);
        idle_cycles(1);
        check_output("to_restart16", {5'd0, item_selector}, 8'd0);

        // Reset after a lone E0: the next byte decodes as a normal code.
        send_byte(8'h09);
        send_byte(8'hE0);
        reset = 1'b0;
        idle_cycles(1);
        reset = 1'b1;
        check_output("mid_rst_sel",   {5'd0, item_selector}, 8'd0);
        check_output("mid_rst_caps",  {7'd0, caps_on},       8'd0);
        check_output("mid_rst_color", {5'd0, text_color},    8'd7);
        check_output("mid_rst_cmdi",  {5'd0, cmd_item},      8'd0);
        send_byte(8'h09);
        check_output("mid_rst_open", {5'd0, item_selector}, 8'd1);
        send_byte(8'h74);
        check_output("mid_rst_74", {5'd0, item_selector}, 8'd1);

        // cmd_valid lasts exactly one cycle and cmd_item holds afterwards.
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'h5A);
        check_output("pulse_hi",   {7'd0, cmd_valid}, 8'd1);
        check_output("pulse_size", {6'd0, text_size}, 8'd1);
        idle_cycles(1);
        check_output("pulse_lo",   {7'd0, cmd_valid}, 8'd0);
        check_output("pulse_hold", {5'd0, cmd_item},  8'd6);
        check_output("pulse_sel",  {5'd0, item_selector}, 8'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
